pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 195 +++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Parametrised pipeline stage register with a valid/ready handshake and a
// 2-entry skid buffer (main + skid). Carries a control field and a data field
// between two pipeline stages. in_ready comes straight from a flop, so the
// stage never has a combinational path from out_ready or in_valid to in_ready.
// Flush drops every held entry and discards the input offered in that cycle.
// Whenever no valid entry is presented, the control field reads as zero.
//
// Optional feature: define PIPE_STAGE_STATS_EN to add the stall_cnt and
// flush_cnt statistics outputs.
//
// Parameters:
//   CTRL_W              width of the control field (cleared on bubble)
//   DATA_W              width of the data field
//   ZERO_DATA_ON_FLUSH  1: flush clears the data registers; 0: data keeps its
//                       stale value
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   flush      in   kill all held and incoming entries
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept (registered, occupancy != 2)
//   in_ctrl    in   upstream control field
//   in_data    in   upstream data field
//   out_valid  out  main entry valid
//   out_ready  in   downstream accepts the main entry this cycle
//   out_ctrl   out  main control field, all-zero when out_valid = 0
//   out_data   out  main data field
//   occupancy  out  entries held: 0, 1 or 2
//   stall_cnt  out  (PIPE_STAGE_STATS_EN) cycles with out_valid & !out_ready
//   flush_cnt  out  (PIPE_STAGE_STATS_EN) cycles with flush asserted
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int CTRL_W             = 10,
  parameter int DATA_W             = 160,
  parameter int ZERO_DATA_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // State is the occupancy itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // What the main register does on the next edge.
  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_FROM_IN,
    MAIN_FROM_SKID,
    MAIN_CLEAR_CTRL
  } main_sel_t;

  state_t      state_q, state_d;
  main_sel_t   main_sel;
  logic        skid_load;
  logic        skid_clear;
  logic        in_ready_q;
  logic        in_acc;
  logic        out_acc;

  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  assign in_acc  = in_valid & in_ready_q;
  assign out_acc = (state_q != EMPTY) & out_ready;

  // Next-state and register-update selection. Flush and reset are applied in
  // the sequential block, where they override everything decided here.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d    = state_q;
    main_sel   = MAIN_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_acc) begin
          main_sel = MAIN_FROM_IN;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (out_acc && in_acc) begin
          main_sel = MAIN_FROM_IN;
        end else if (out_acc) begin
          // Main drains: zero its control so the bubble reads as all-zero.
          main_sel = MAIN_CLEAR_CTRL;
          state_d  = EMPTY;
        end else if (in_acc) begin
          skid_load = 1'b1;
          state_d   = TWO;
        end
      end
      TWO: begin
        // in_ready is low here, so only the output side can move.
        if (out_acc) begin
          main_sel   = MAIN_FROM_SKID;
          skid_clear = 1'b1;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      // Both held entries and the offered input are dropped together.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      if (ZERO_DATA_ON_FLUSH != 0) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end
    end else begin
      state_q    <= state_d;
      // Registered copy of (next occupancy != 2): no combinational path in.
      in_ready_q <= (state_d != TWO);

      unique case (main_sel)
        MAIN_FROM_IN: begin
          main_ctrl_q <= in_ctrl;
          main_data_q <= in_data;
        end
        MAIN_FROM_SKID: begin
          main_ctrl_q <= skid_ctrl_q;
          main_data_q <= skid_data_q;
        end
        MAIN_CLEAR_CTRL: main_ctrl_q <= '0;
        default: ;
      endcase

      if (skid_load) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end else if (skid_clear) begin
        skid_ctrl_q <= '0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_STATS_EN
  // Free-running statistics; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                   flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Directed testbench for pipe_stage_skid. Two instances share all inputs: the
// default build (data cleared on flush) and one with ZERO_DATA_ON_FLUSH = 0,
// used to check that flush leaves its data untouched. Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int CTRL_W = 10;
  localparam int DATA_W = 160;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              in_ready,  k_in_ready;
  logic              out_valid, k_out_valid;
  logic [CTRL_W-1:0] out_ctrl,  k_out_ctrl;
  logic [DATA_W-1:0] out_data,  k_out_data;
  logic [1:0]        occupancy, k_occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt, flush_cnt, k_stall_cnt, k_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_DATA_ON_FLUSH(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_DATA_ON_FLUSH(0)
  ) dut_keep (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(k_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(k_out_valid), .out_ready(out_ready), .out_ctrl(k_out_ctrl),
    .out_data(k_out_data), .occupancy(k_occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(k_stall_cnt), .flush_cnt(k_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // Full view of the main entry plus occupancy and in_ready.
  task automatic expect_out(input string tag, input logic v,
                            input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                            input logic [1:0] occ, input logic rdy);
    check({tag, ".valid"}, DATA_W'(out_valid), DATA_W'(v));
    check({tag, ".ctrl"},  DATA_W'(out_ctrl),  DATA_W'(c));
    check({tag, ".data"},  out_data,           d);
    check({tag, ".occ"},   DATA_W'(occupancy), DATA_W'(occ));
    check({tag, ".rdy"},   DATA_W'(in_ready),  DATA_W'(rdy));
  endtask

  initial begin
    // ---------------- reset with in_valid held high ----------------
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 10'h3FF, 160'h99);
    step(); step();
    rst = 1'b0;
    drive(1'b0, '0, '0);
    step();
    expect_out("reset", 1'b0, 10'h000, 160'h0, 2'd0, 1'b1);
    check("reset.keep_data", k_out_data, 160'h0);

    // ---------------- streaming, out_ready held high ----------------
    out_ready = 1'b1;
    drive(1'b1, 10'h3FF, 160'h1); step();
    expect_out("stream0", 1'b1, 10'h3FF, 160'h1, 2'd1, 1'b1);
    drive(1'b1, 10'h155, 160'h2); step();
    expect_out("stream1", 1'b1, 10'h155, 160'h2, 2'd1, 1'b1);
    drive(1'b1, 10'h2AA, 160'h3); step();
    expect_out("stream2", 1'b1, 10'h2AA, 160'h3, 2'd1, 1'b1);
    drive(1'b0, '0, '0); step();
    // Last entry drained: bubble has zero control, data is left as it was.
    expect_out("stream_drain", 1'b0, 10'h000, 160'h3, 2'd0, 1'b1);

    // ---------------- backpressure: A, B, then C held off ----------------
    out_ready = 1'b0;
    drive(1'b1, 10'h011, 160'hA); step();
    expect_out("bp_a", 1'b1, 10'h011, 160'hA, 2'd1, 1'b1);
    drive(1'b1, 10'h022, 160'hB); step();
    expect_out("bp_full", 1'b1, 10'h011, 160'hA, 2'd2, 1'b0);
    drive(1'b1, 10'h033, 160'hC); step();
    expect_out("bp_c_held", 1'b1, 10'h011, 160'hA, 2'd2, 1'b0);
    out_ready = 1'b1; step();
    expect_out("bp_b_out", 1'b1, 10'h022, 160'hB, 2'd1, 1'b1);
    step();
    expect_out("bp_c_out", 1'b1, 10'h033, 160'hC, 2'd1, 1'b1);
    drive(1'b0, '0, '0); step();
    expect_out("bp_drain", 1'b0, 10'h000, 160'hC, 2'd0, 1'b1);

    // ---------------- flush while full, D offered ----------------
    out_ready = 1'b0;
    drive(1'b1, 10'h044, 160'hE); step();
    drive(1'b1, 10'h055, 160'hF); step();
    expect_out("fl_full", 1'b1, 10'h044, 160'hE, 2'd2, 1'b0);
    flush = 1'b1;
    drive(1'b1, 10'h066, 160'hD); step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    expect_out("fl_after", 1'b0, 10'h000, 160'h0, 2'd0, 1'b1);
    check("fl_keep.valid", DATA_W'(k_out_valid), DATA_W'(1'b0));
    check("fl_keep.ctrl",  DATA_W'(k_out_ctrl),  DATA_W'(10'h000));
    check("fl_keep.data",  k_out_data,           160'hE);
    out_ready = 1'b1; step();
    expect_out("fl_no_d", 1'b0, 10'h000, 160'h0, 2'd0, 1'b1);

    // ---------------- accept during in_ready=1 flush cycle ----------------
    // in_ready is high (EMPTY) yet the offered entry must be discarded.
    flush = 1'b1;
    drive(1'b1, 10'h077, 160'h7); step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    expect_out("fl_empty_drop", 1'b0, 10'h000, 160'h0, 2'd0, 1'b1);

    // ---------------- simultaneous flush and reset ----------------
    out_ready = 1'b0;
    drive(1'b1, 10'h088, 160'h8); step();
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 10'h099, 160'h9); step();
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0);
    expect_out("rst_fl", 1'b0, 10'h000, 160'h0, 2'd0, 1'b1);
    check("rst_fl.keep_data", k_out_data, 160'h0);
`ifdef PIPE_STAGE_STATS_EN
    check("rst_fl.flush_cnt", DATA_W'(flush_cnt), DATA_W'(32'd0));
    check("rst_fl.stall_cnt", DATA_W'(stall_cnt), DATA_W'(32'd0));
`endif

    // ---------------- 5 stall cycles, then one flush ----------------
    out_ready = 1'b0;
    drive(1'b1, 10'h0AB, 160'h5); step();   // accepted; out_valid was 0 at this edge
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) step();     // out_valid=1, out_ready=0 at each edge
    expect_out("stall_hold", 1'b1, 10'h0AB, 160'h5, 2'd1, 1'b1);
    // out_ready high during the flush so the flush cycle is not a stall.
    out_ready = 1'b1; flush = 1'b1; step();
    flush = 1'b0; out_ready = 1'b0;
    expect_out("stall_flushed", 1'b0, 10'h000, 160'h0, 2'd0, 1'b1);
`ifdef PIPE_STAGE_STATS_EN
    check("stats.stall_cnt", DATA_W'(stall_cnt), DATA_W'(32'd5));
    check("stats.flush_cnt", DATA_W'(flush_cnt), DATA_W'(32'd1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
